// File: rtl/uart_status_tx_if.sv
// uart_status_tx_if: status event intake and uart transmit-byte handshake
interface uart_status_tx_if;
    logic        evt_valid;
    logic [2:0]  evt_code;
    logic [15:0] evt_value;
    logic        evt_ready;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_busy;
    modport master (output evt_valid, evt_code, evt_value, tx_busy, input evt_ready, tx_start, tx_byte);
    modport slave (input evt_valid, evt_code, evt_value, tx_busy, output evt_ready, tx_start, tx_byte);
endinterface

// File: rtl/uart_status_tx.sv
// uart_status_tx: buffers game status events and serialises each as an 8-byte ASCII record to the uart
module uart_status_tx #(
    parameter int QDEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_status_tx_if.slave  bus,
    output logic [7:0]       drop_cnt,
    output logic             idle
);
    localparam int AW = $clog2(QDEPTH);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, GUARD, WAIT} state_t;
    state_t        state;
    logic [18:0]   mem [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [2:0]    rec_code, idx;
    logic [15:0]   rec_value;
    logic          full, push, pop;
    logic [7:0]    prefix, cur_byte;
    logic [3:0]    nib;
    assign full = count == (AW+1)'(QDEPTH);
    assign push = bus.evt_valid && !full;
    assign pop = state == IDLE && count != '0;
    assign bus.evt_ready = !full;
    assign idle = state == IDLE && count == '0;
    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
    // record layout: prefix ':' hex3 hex2 hex1 hex0 CR LF
    always_comb begin
        prefix = rec_code == 3'd0 ? 8'h53 :
                 rec_code == 3'd1 ? 8'h4C :
                 rec_code == 3'd2 ? 8'h48 :
                 rec_code == 3'd3 ? 8'h47 :
                 rec_code == 3'd4 ? 8'h4E : 8'h3F;
        nib = idx == 3'd2 ? rec_value[15:12] :
              idx == 3'd3 ? rec_value[11:8]  :
              idx == 3'd4 ? rec_value[7:4]   : rec_value[3:0];
        cur_byte = idx == 3'd0 ? prefix :
                   idx == 3'd1 ? 8'h3A  :
                   idx == 3'd6 ? 8'h0D  :
                   idx == 3'd7 ? 8'h0A  : hex(nib);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            drop_cnt     <= '0;
            idx          <= '0;
            rec_code     <= '0;
            rec_value    <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_byte  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.evt_code, bus.evt_value};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push != pop)
                count <= push ? count + 1'b1 : count - 1'b1;
            if (bus.evt_valid && full && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
            bus.tx_start <= state == LOAD;
            case (state)
                IDLE:
                    if (pop) begin
                        {rec_code, rec_value} <= mem[rd_ptr];
                        idx                   <= '0;
                        state                 <= LOAD;
                    end
                LOAD: begin
                    bus.tx_byte <= cur_byte;
                    state       <= SEND;
                end
                SEND:  state <= GUARD;
                GUARD: state <= WAIT;
                WAIT:
                    if (!bus.tx_busy) begin
                        idx   <= idx + 1'b1;
                        state <= idx == 3'd7 ? IDLE : LOAD;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_status_tx.sv
// tb_uart_status_tx: directed record-table checks plus overflow, saturation and mid-record reset sequences
module tb_uart_status_tx;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] drop_cnt;
    logic       idle;
    uart_status_tx_if bus();
    uart_status_tx #(.QDEPTH(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .drop_cnt(drop_cnt),
        .idle(idle)
    );
    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         busy_len = 20;
    logic       hold_busy = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] got[$];

    // uart model: busy for busy_len cycles after each accepted byte, or forced busy
    always @(posedge clk) busy_cnt <= bus.tx_start ? busy_len : (busy_cnt != 0 ? busy_cnt - 1 : 0);
    assign bus.tx_busy = hold_busy || busy_cnt != 0;
    always @(negedge clk) if (bus.tx_start) got.push_back(bus.tx_byte);

    typedef struct {
        logic [2:0]  code;
        logic [15:0] value;
        logic [63:0] rec;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_evt(input logic [2:0] c, input logic [15:0] v);
        bus.evt_valid = 1'b1;
        bus.evt_code = c;
        bus.evt_value = v;
        @(negedge clk);
        bus.evt_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string name);
        int n = 0;
        while (!idle && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(name, idle, 1'b1);
    endtask

    task automatic wait_pulses(input int from, input int upto, input string name);
        int pc = from;
        int n = 0;
        while (pc < upto && n < 500) begin
            @(negedge clk);
            n++;
            if (bus.tx_start) pc++;
        end
        chk(name, pc, upto);
    endtask

    function automatic logic [63:0] rec_at(input int b);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++)
            r = {r[55:0], (b + i < got.size()) ? got[b + i] : 8'h00};
        return r;
    endfunction

    initial begin
        int n;
        vecs[0] = '{3'd0, 16'h1A2F, {"S:1A2F", 8'h0D, 8'h0A}};
        vecs[1] = '{3'd1, 16'h0000, {"L:0000", 8'h0D, 8'h0A}};
        vecs[2] = '{3'd2, 16'hFFFF, {"H:FFFF", 8'h0D, 8'h0A}};
        vecs[3] = '{3'd3, 16'h0009, {"G:0009", 8'h0D, 8'h0A}};
        vecs[4] = '{3'd4, 16'h000A, {"N:000A", 8'h0D, 8'h0A}};
        vecs[5] = '{3'd7, 16'h1234, {"?:1234", 8'h0D, 8'h0A}};
        bus.evt_valid = 1'b0;
        bus.evt_code = '0;
        bus.evt_value = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.evt_ready, 1'b1);
        chk("rst_tx_start", bus.tx_start, 1'b0);
        chk("rst_tx_byte", bus.tx_byte, 8'h00);
        chk("rst_drop", drop_cnt, 8'h00);
        chk("rst_idle", idle, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);

        // single record and first-pulse latency
        push_evt(vecs[0].code, vecs[0].value);
        n = 0;
        while (!bus.tx_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 2);
        wait_idle(1000, "idle_single");
        chk("pulses_single", got.size(), 8);
        chk("rec_single", rec_at(0), vecs[0].rec);

        // back-to-back records from the table
        got.delete();
        for (int i = 1; i < 6; i++) push_evt(vecs[i].code, vecs[i].value);
        wait_idle(3000, "idle_table");
        chk("pulses_table", got.size(), 40);
        for (int i = 1; i < 6; i++) chk($sformatf("rec_table_%0d", i), rec_at((i - 1) * 8), vecs[i].rec);

        // overflow with the uart held busy
        got.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("ready_before_%0d", i), bus.evt_ready, i < 9);
            push_evt(3'd0, 16'(i));
        end
        chk("drop_one", drop_cnt, 8'd1);
        hold_busy = 1'b0;
        wait_idle(5000, "idle_overflow");
        chk("pulses_overflow", got.size(), 72);
        for (int k = 0; k < 9; k++)
            chk($sformatf("rec_overflow_%0d", k), rec_at(k * 8), {"S:000", 8'(8'h30 + k), 8'h0D, 8'h0A});

        // offer while full in the same cycle the FSM pops
        got.delete();
        busy_len = 0;
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) push_evt(3'd1, 16'(i));
        chk("full_before_pop", bus.evt_ready, 1'b0);
        hold_busy = 1'b0;
        wait_pulses(1, 8, "pulses_to_lf");
        repeat (3) @(negedge clk);
        chk("full_at_pop", bus.evt_ready, 1'b0);
        push_evt(3'd5, 16'hDEAD);
        chk("drop_at_pop", drop_cnt, 8'd2);
        chk("ready_after_pop", bus.evt_ready, 1'b1);
        push_evt(3'd6, 16'hBEEF);
        chk("refilled", bus.evt_ready, 1'b0);
        wait_idle(5000, "idle_pop");
        chk("pulses_pop", got.size(), 80);
        chk("rec_refill", rec_at(72), {"?:BEEF", 8'h0D, 8'h0A});

        // drop counter saturation
        busy_len = 20;
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) push_evt(3'd2, 16'(i));
        bus.evt_valid = 1'b1;
        repeat (300) @(negedge clk);
        bus.evt_valid = 1'b0;
        chk("drop_saturated", drop_cnt, 8'd255);
        chk("still_full", bus.evt_ready, 1'b0);

        // reset after the third byte of a record
        hold_busy = 1'b0;
        wait_pulses(1, 3, "pulses_to_third");
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        got.delete();
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx_start) n++;
        end
        chk("no_tx_after_reset", n, 0);
        chk("idle_after_reset", idle, 1'b1);
        chk("ready_after_reset", bus.evt_ready, 1'b1);
        chk("drop_after_reset", drop_cnt, 8'd0);
        push_evt(3'd4, 16'h0042);
        wait_idle(1000, "idle_after_reset_rec");
        chk("pulses_after_reset", got.size(), 8);
        chk("rec_after_reset", rec_at(0), {"N:0042", 8'h0D, 8'h0A});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_status_tx.md
Name: uart_status_tx

Overview:
Transmit-side companion to the game's UART command input path. Accepts game status events (score, lines, hold, game-over, next piece) from the game FSM, buffers them in a small FIFO, and serialises each as a fixed 8-byte ASCII record onto the uart transmit byte interface (transmit / tx_byte / is_transmitting). It sits between the game core and the shared uart instance, driving the uart's previously tied-off transmit inputs.

Parameters:
QDEPTH, 8, event FIFO depth in entries; must be a power of 2, at least 2.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
evt_valid  in  1  event offered this cycle
evt_code  in  3  event type
evt_value  in  16  event payload
evt_ready  out  1  FIFO not full; event accepted when evt_valid && evt_ready
tx_start  out  1  one-cycle pulse; connects to uart transmit
tx_byte  out  8  byte to send; valid while tx_start is high
tx_busy  in  1  uart is_transmitting
drop_cnt  out  8  saturating count of events offered while FIFO full
idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset is synchronous, active-low (reset_n), on clk. Reset takes effect mid-record: FIFO is emptied, FSM goes to IDLE, the partial record is abandoned, and no further tx_start is issued.
- Reset values: evt_ready=1, tx_start=0, tx_byte=0, drop_cnt=0, idle=1.
- Record format, 8 bytes in order: prefix, ':', hex3, hex2, hex1, hex0, 0x0D, 0x0A.
  - hexN is evt_value[4N+3:4N] as uppercase ASCII '0'-'9' / 'A'-'F'.
  - Prefix by evt_code: 0 'S' (score), 1 'L' (lines), 2 'H' (hold), 3 'G' (game over), 4 'N' (next piece), 5-7 '?'.
- FIFO:
  - Entries are {code, value}.
  - Count is registered, width clog2(QDEPTH)+1; read and write pointers wrap modulo QDEPTH.
  - evt_ready = (count != QDEPTH).
  - Push and pop in the same cycle both take effect and leave count unchanged.
  - No bypass: an accepted event is first visible to the FSM the next cycle.
- Overflow:
  - evt_valid while full drops the event; the FIFO is unchanged.
  - drop_cnt increments by 1 and saturates at 255.
  - A pop in the same cycle does not rescue the event, because evt_ready was already 0.
- FSM states: IDLE, LOAD, SEND, GUARD, WAIT.
  - IDLE: if count != 0, pop the head into the record register, clear the byte index to 0, go to LOAD.
  - LOAD: drive tx_byte = record byte[index], go to SEND.
  - SEND: tx_start=1 for exactly this cycle with tx_byte stable, go to GUARD.
  - GUARD: one cycle with no checks; covers the uart's one-cycle latency before is_transmitting rises. Go to WAIT.
  - WAIT: hold while tx_busy=1. When tx_busy=0: if index==7, go to IDLE; otherwise increment index and go to LOAD.
- tx_byte holds its last value outside SEND; it is only meaningful during the tx_start cycle.
- Latency: an event accepted at edge t gives tx_start high in cycle t+3 (IDLE pop at t+1, LOAD at t+2, SEND at t+3), provided the FSM was idle.
- Minimum spacing between successive tx_start pulses is 4 cycles plus the uart busy time. A new record never begins until the LF of the previous record is complete.
- Back-to-back records: WAIT exits to IDLE, and IDLE pops the next entry on the following cycle. There is no dead time beyond the IDLE cycle itself.
- idle = (state==IDLE) && (count==0).
- tx_busy high while in IDLE, LOAD or SEND is ignored. The FSM only waits on it in WAIT.

Test Plan:
- Reset, then one event code=0, value=0x1A2F, with a uart model whose busy time is 20 cycles → exactly 8 tx_start pulses. Bytes are 0x53 0x3A 0x31 0x41 0x32 0x46 0x0D 0x0A. First pulse is 3 cycles after acceptance; idle returns to 1 after the last byte completes.
- Codes 1,2,3,4,7 pushed on consecutive cycles with values 0x0000, 0xFFFF, 0x0009, 0x000A, 0x1234 → records "L:0000", "H:FFFF", "G:0009", "N:000A", "?:1234", each ending CR LF, in order, with no interleaving.
- Hold tx_busy=1 indefinitely and push 10 events with QDEPTH=8 → the first event is popped, so 8 more are buffered. evt_ready goes low after the 9th accepted event, and the 10th is dropped giving drop_cnt=1. Release tx_busy → 9 complete records are sent.
- With the FIFO full and the FSM popping, assert evt_valid in the same cycle as the pop → event dropped and drop_cnt increments. Next cycle evt_ready=1 and a push succeeds.
- Offer 300 events while full → drop_cnt saturates at 255.
- Assert reset_n=0 for one cycle after the 3rd tx_start of a record → no further tx_start, FIFO empty, evt_ready=1, idle=1, drop_cnt=0. A subsequent event transmits a full 8-byte record starting at the prefix.
